// File: rtl/seg_scan_pkg.sv
// seg_scan_pkg: shared types and widths for the 7-segment scan controller
package seg_scan_pkg;
    localparam int CODE_W = 3;
    typedef enum logic {ST_BLANK, ST_SHOW} state_e;
endpackage

// File: rtl/seg_scan_timer.sv
// seg_scan_timer: per-slot cycle counter with blank-end, pre-end and slot-end strobes
module seg_scan_timer #(
    parameter int SLOT_CYCLES  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic clk,
    input  logic rst_n,
    output logic blank_end,
    output logic slot_pre,
    output logic slot_end
);
    localparam int CNT_W = $clog2(SLOT_CYCLES);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    always_comb begin
        blank_end = cnt_q == CNT_W'(BLANK_CYCLES - 1);
        slot_pre  = cnt_q == CNT_W'(SLOT_CYCLES - 2);
        slot_end  = cnt_q == CNT_W'(SLOT_CYCLES - 1);
        cnt_d     = slot_end ? '0 : cnt_q + CNT_W'(1);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexed 7-seg digit scanner with blanking gaps and tear-free frame updates.
// Define SEG_SCAN_LZ_BLANK_EN to keep leading-zero digits dark.
module seg_scan_ctrl
    import seg_scan_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SLOT_CYCLES  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         upd_valid,
    output logic                         upd_ready,
    input  logic [CODE_W*NUM_DIGITS-1:0] upd_codes,
    output logic [CODE_W-1:0]            code,
    output logic [NUM_DIGITS-1:0]        dig_en,
    output logic                         frame_done
);
    localparam int IDX_W = $clog2(NUM_DIGITS);
    state_e                           state_q, state_d;
    logic [IDX_W-1:0]                 idx_q, idx_d;
    logic [NUM_DIGITS-1:0][CODE_W-1:0] shadow_q, shadow_d, pend_q, pend_d;
    logic                             pend_full_q, pend_full_d;
    logic [CODE_W-1:0]                code_q, code_d;
    logic [NUM_DIGITS-1:0]            dig_en_q, dig_en_d;
    logic                             frame_done_q, frame_done_d;
    logic                             blank_end, slot_pre, slot_end, lz_blank, last_idx;

    seg_scan_timer #(
        .SLOT_CYCLES (SLOT_CYCLES),
        .BLANK_CYCLES(BLANK_CYCLES)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .blank_end(blank_end),
        .slot_pre (slot_pre),
        .slot_end (slot_end)
    );

    assign last_idx = idx_q == IDX_W'(NUM_DIGITS - 1);

`ifdef SEG_SCAN_LZ_BLANK_EN
    // Dark when this digit and every more significant digit are zero; digit 0 always lit.
    always_comb begin
        lz_blank = idx_q != '0;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (IDX_W'(i) >= idx_q && shadow_q[i] != '0) lz_blank = 1'b0;
    end
`else
    assign lz_blank = 1'b0;
`endif

    // Code and enable load together so the decoder never sees a stale code on a lit digit.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        code_d       = code_q;
        dig_en_d     = dig_en_q;
        frame_done_d = slot_pre && last_idx;
        if (state_q == ST_BLANK && blank_end) begin
            state_d  = ST_SHOW;
            code_d   = shadow_q[idx_q];
            dig_en_d = lz_blank ? '0 : NUM_DIGITS'(1) << idx_q;
        end
        if (state_q == ST_SHOW && slot_end) begin
            state_d  = ST_BLANK;
            dig_en_d = '0;
            idx_d    = last_idx ? '0 : idx_q + IDX_W'(1);
        end
    end

    // Accept and commit are exclusive: accept needs the buffer empty, commit needs it full.
    always_comb begin
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        shadow_d    = shadow_q;
        if (upd_valid && !pend_full_q) begin
            pend_d      = upd_codes;
            pend_full_d = 1'b1;
        end else if (frame_done_q && pend_full_q) begin
            shadow_d    = pend_q;
            pend_full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_BLANK;
            idx_q        <= '0;
            shadow_q     <= '0;
            pend_q       <= '0;
            pend_full_q  <= 1'b0;
            code_q       <= '0;
            dig_en_q     <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            pend_q       <= pend_d;
            pend_full_q  <= pend_full_d;
            code_q       <= code_d;
            dig_en_q     <= dig_en_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign upd_ready  = !pend_full_q;
    assign code       = code_q;
    assign dig_en     = dig_en_q;
    assign frame_done = frame_done_q;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: cycle-accurate reference model plus directed scan/update/reset scenarios
module tb_seg_scan_ctrl;
    localparam int ND = 4;
    localparam int SC = 8;
    localparam int BC = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          upd_valid = 1'b0;
    logic [3*ND-1:0] upd_codes = '0;
    logic          upd_ready;
    logic [2:0]    code;
    logic [ND-1:0] dig_en;
    logic          frame_done;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    int          t = 0;
    logic [11:0] m_shadow = '0;
    logic [11:0] m_pend = '0;
    bit          m_full = 1'b0;

    always #5 clk = ~clk;

    seg_scan_ctrl #(.NUM_DIGITS(ND), .SLOT_CYCLES(SC), .BLANK_CYCLES(BC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .upd_valid (upd_valid),
        .upd_ready (upd_ready),
        .upd_codes (upd_codes),
        .code      (code),
        .dig_en    (dig_en),
        .frame_done(frame_done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: t counts cycles since reset release; slot and digit follow from division.
    always @(negedge clk) begin
        int cnt;
        int idx;
        bit fd;
        logic [3:0] ee;
        logic [2:0] ec;
        if (!rst_n) begin
            chk("m_rst_dig_en", 32'(dig_en), 32'd0);
            chk("m_rst_code", 32'(code), 32'd0);
            chk("m_rst_frame_done", 32'(frame_done), 32'd0);
            chk("m_rst_ready", 32'(upd_ready), 32'd1);
            t = 0;
            m_shadow = '0;
            m_pend = '0;
            m_full = 1'b0;
        end else begin
            cnt = t % SC;
            idx = (t / SC) % ND;
            fd  = (cnt == SC - 1) && (idx == ND - 1);
            ec  = 3'((m_shadow >> (3 * idx)) & 12'h7);
            ee  = (cnt >= BC) ? 4'(1 << idx) : 4'b0;
`ifdef SEG_SCAN_LZ_BLANK_EN
            if (idx != 0 && (m_shadow >> (3 * idx)) == '0) ee = 4'b0;
`endif
            chk("m_dig_en", 32'(dig_en), 32'(ee));
            chk("m_frame_done", 32'(frame_done), 32'(fd));
            chk("m_ready", 32'(upd_ready), 32'(!m_full));
            if (cnt >= BC) chk("m_code", 32'(code), 32'(ec));
            if (upd_valid && !m_full) begin
                m_pend = upd_codes;
                m_full = 1'b1;
            end else if (fd && m_full) begin
                m_shadow = m_pend;
                m_full = 1'b0;
            end
            t++;
        end
    end

    task automatic go(input int n);
        repeat (n) @(posedge clk);
        #2;
        cyc += n;
    endtask

    task automatic go_to(input int c);
        go(c - cyc);
    endtask

    initial begin
        int w;
        #1 rst_n = 1'b0;
        go(3);
        chk("rst_dig_en", 32'(dig_en), 32'd0);
        chk("rst_code", 32'(code), 32'd0);
        chk("rst_ready", 32'(upd_ready), 32'd1);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        rst_n = 1'b1;
        cyc = 0;
        go_to(1);  chk("boot_blank", 32'(dig_en), 32'd0);
        go_to(2);  chk("first_show", 32'(dig_en), 32'd1);
        go_to(8);  chk("gap_blank", 32'(dig_en), 32'd0);
        go_to(10); chk("d1_show", 32'(dig_en), 32'd2);
        upd_codes = 12'o7531;
        upd_valid = 1'b1;
        go_to(11);
        upd_valid = 1'b0;
        chk("busy_after_accept", 32'(upd_ready), 32'd0);
        go_to(26); chk("d3_show", 32'(dig_en), 32'd8);
        chk("old_code_kept", 32'(code), 32'd0);
        go_to(31); chk("frame_done_31", 32'(frame_done), 32'd1);
        go_to(32); chk("ready_after_commit", 32'(upd_ready), 32'd1);
        chk("frame_done_pulse", 32'(frame_done), 32'd0);
        go_to(34); chk("new_d0_en", 32'(dig_en), 32'd1);
        chk("new_d0_code", 32'(code), 32'd1);
        go_to(42); chk("new_d1_code", 32'(code), 32'd3);
        go_to(50); chk("new_d2_code", 32'(code), 32'd5);
        go_to(58); chk("new_d3_code", 32'(code), 32'd7);
        go_to(63); chk("frame_done_63", 32'(frame_done), 32'd1);
        go_to(64);
        upd_codes = 12'o1234;
        upd_valid = 1'b1;
        go_to(65);
        upd_codes = 12'o4567;
        w = 0;
        while (!upd_ready && w < 60) begin
            go(1);
            w++;
        end
        chk("second_accept_cycle", 32'(cyc), 32'd96);
        go(1);
        upd_valid = 1'b0;
        chk("second_pending", 32'(upd_ready), 32'd0);
        go_to(98);  chk("a_d0_code", 32'(code), 32'd4);
        go_to(106); chk("a_d1_code", 32'(code), 32'd3);
        go_to(130); chk("b_d0_code", 32'(code), 32'd7);
        go_to(146);
        chk("d2_show_mid", 32'(dig_en), 32'd4);
        upd_codes = 12'o7777;
        upd_valid = 1'b1;
        go_to(147);
        upd_valid = 1'b0;
        chk("c_pending", 32'(upd_ready), 32'd0);
        go_to(148);
        rst_n = 1'b0;
        #1;
        chk("async_dark", 32'(dig_en), 32'd0);
        chk("async_ready", 32'(upd_ready), 32'd1);
        go(2);
        rst_n = 1'b1;
        cyc = 0;
        go_to(2);  chk("restart_d0", 32'(dig_en), 32'd1);
        chk("restart_code", 32'(code), 32'd0);
        go_to(34); chk("pending_discarded", 32'(code), 32'd0);
        go_to(40);
        upd_codes = 12'o0030;
        upd_valid = 1'b1;
        go_to(41);
        upd_valid = 1'b0;
        go_to(66); chk("lz_d0_en", 32'(dig_en), 32'd1);
        chk("lz_d0_code", 32'(code), 32'd0);
        go_to(74); chk("lz_d1_en", 32'(dig_en), 32'd2);
        chk("lz_d1_code", 32'(code), 32'd3);
`ifdef SEG_SCAN_LZ_BLANK_EN
        go_to(82); chk("lz_d2_dark", 32'(dig_en), 32'd0);
        go_to(90); chk("lz_d3_dark", 32'(dig_en), 32'd0);
`else
        go_to(82); chk("lz_d2_lit", 32'(dig_en), 32'd4);
        go_to(90); chk("lz_d3_lit", 32'(dig_en), 32'd8);
`endif
        go_to(95); chk("lz_frame_done", 32'(frame_done), 32'd1);
        go_to(100);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
